// File: rtl/uart_tx.sv
// ---------------------------------------------------------------------------
// uart_tx -- asynchronous serial transmitter.
//
// Accepts one byte per XMitGo request from the TX driver and sends it on
// TxOut as 1 start bit, 8 data bits (LSB first), an optional even-parity
// bit and 1 stop bit. Each bit lasts CLKS_PER_BIT clocks.
//
// Build option:
//   UART_TX_PARITY_EN  when defined, an even-parity bit is sent after the
//                      data bits (11-bit frame); otherwise 10-bit frame.
//
// Ports:
//   Clock    in   system clock
//   Reset    in   synchronous, active-high reset
//   XMitGo   in   driver request to transmit TxData
//   TxData   in   [7:0] byte to send, sampled only when a request is accepted
//   TxEmpty  out  high = idle and able to accept a byte
//   TxOut    out  serial line, idles high, always driven from a register
// ---------------------------------------------------------------------------
module uart_tx #(
   parameter int unsigned CLKS_PER_BIT = 434
) (
   input  logic       Clock,
   input  logic       Reset,
   input  logic       XMitGo,
   input  logic [7:0] TxData,
   output logic       TxEmpty,
   output logic       TxOut
);

   localparam int unsigned       BAUD_W    = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
   localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);

`ifdef UART_TX_PARITY_EN
   typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
`else
   typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;
`endif

   state_t            state;
   logic [BAUD_W-1:0] baud;
   logic [2:0]        bitcnt;
   logic [7:0]        shift;
   logic              armed;     // cleared on accept, set whenever XMitGo is seen low
   logic              bit_end;
`ifdef UART_TX_PARITY_EN
   logic              par_bit;
`endif

   assign bit_end = (baud == BAUD_LAST);

   always_ff @(posedge Clock) begin
      if (Reset) begin
         state   <= IDLE;
         baud    <= '0;
         bitcnt  <= '0;
         shift   <= '0;
         armed   <= 1'b1;
         TxEmpty <= 1'b1;
         TxOut   <= 1'b1;
`ifdef UART_TX_PARITY_EN
         par_bit <= 1'b0;
`endif
      end else begin
         if (!XMitGo)
            armed <= 1'b1;

         // Baud counter free-runs in every busy state and restarts per bit.
         if (state != IDLE)
            baud <= bit_end ? '0 : baud + BAUD_W'(1);

         case (state)
            IDLE: begin
               if (XMitGo && armed) begin
                  shift   <= TxData;
`ifdef UART_TX_PARITY_EN
                  par_bit <= ^TxData;
`endif
                  armed   <= 1'b0;
                  TxEmpty <= 1'b0;
                  TxOut   <= 1'b0;
                  baud    <= '0;
                  bitcnt  <= '0;
                  state   <= START;
               end
            end

            START: begin
               if (bit_end) begin
                  TxOut <= shift[0];
                  state <= DATA;
               end
            end

            DATA: begin
               if (bit_end) begin
                  if (bitcnt == 3'd7) begin
`ifdef UART_TX_PARITY_EN
                     TxOut <= par_bit;
                     state <= PARITY;
`else
                     TxOut <= 1'b1;
                     state <= STOP;
`endif
                  end else begin
                     // Present the next bit directly so TxOut stays registered.
                     shift  <= {1'b0, shift[7:1]};
                     TxOut  <= shift[1];
                     bitcnt <= bitcnt + 3'd1;
                  end
               end
            end

`ifdef UART_TX_PARITY_EN
            PARITY: begin
               if (bit_end) begin
                  TxOut <= 1'b1;
                  state <= STOP;
               end
            end
`endif

            STOP: begin
               if (bit_end) begin
                  TxEmpty <= 1'b1;
                  state   <= IDLE;
               end
            end

            default: begin
               TxOut   <= 1'b1;
               TxEmpty <= 1'b1;
               state   <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_uart_tx.sv
// ---------------------------------------------------------------------------
// tb_uart_tx -- directed self-checking bench for uart_tx with CLKS_PER_BIT=4.
// Inputs are driven and outputs sampled on the falling clock edge. A small
// serial receiver model decodes TxOut independently for the loopback test.
// Define UART_TX_PARITY_EN for both bench and RTL to cover the parity build.
// ---------------------------------------------------------------------------
module tb_uart_tx;

   localparam int C = 4;
`ifdef UART_TX_PARITY_EN
   localparam int NB = 11;
`else
   localparam int NB = 10;
`endif

   logic       Clock;
   logic       Reset;
   logic       XMitGo;
   logic [7:0] TxData;
   logic       TxEmpty;
   logic       TxOut;

   int npass  = 0;
   int ntotal = 0;

   uart_tx #(.CLKS_PER_BIT(C)) dut (
      .Clock   (Clock),
      .Reset   (Reset),
      .XMitGo  (XMitGo),
      .TxData  (TxData),
      .TxEmpty (TxEmpty),
      .TxOut   (TxOut)
   );

   initial Clock = 1'b0;
   always #5 Clock = ~Clock;

   // Serial receiver model: detect start, sample mid-bit, record bytes and
   // the length of the high run that preceded each start bit.
   logic       rx_busy;
   int         rx_k;
   int         hi_run;
   logic [7:0] rx_sh;
   logic [7:0] rx_q[$];
   logic       rx_stop_q[$];
   int         gap_q[$];

   always @(negedge Clock) begin
      if (Reset) begin
         rx_busy <= 1'b0;
         rx_k    <= 0;
         hi_run  <= 0;
      end else if (!rx_busy) begin
         if (TxOut === 1'b0) begin
            rx_busy <= 1'b1;
            rx_k    <= 1;
            gap_q.push_back(hi_run);
            hi_run  <= 0;
         end else begin
            hi_run <= hi_run + 1;
         end
      end else begin
         rx_k <= rx_k + 1;
         if (rx_k % C == C / 2) begin
            if (rx_k / C >= 1 && rx_k / C <= 8)
               rx_sh[rx_k / C - 1] <= TxOut;
            if (rx_k / C == NB - 1) begin
               rx_q.push_back(rx_sh);
               rx_stop_q.push_back(TxOut);
               rx_busy <= 1'b0;
            end
         end
      end
   end

   function automatic logic [10:0] frame_of(input logic [7:0] d);
`ifdef UART_TX_PARITY_EN
      return {1'b1, ^d, d, 1'b0};
`else
      return {1'b0, 1'b1, d, 1'b0};
`endif
   endfunction

   // Called on the falling edge just after the accept edge; records the first
   // sample of each bit, whether every bit held steady, and TxEmpty low time.
   task automatic capture_frame(input int nb, output logic [10:0] bits,
                                output logic stable, output int low);
      bits   = '0;
      stable = 1'b1;
      low    = 0;
      for (int k = 0; k < nb * C; k++) begin
         if (k % C == 0)
            bits[k / C] = TxOut;
         else if (TxOut !== bits[k / C])
            stable = 1'b0;
         if (TxEmpty === 1'b0)
            low++;
         @(negedge Clock);
      end
   endtask

   task automatic test_reset();
      int bad;
      Reset = 1'b1; XMitGo = 1'b0; TxData = 8'h00;
      repeat (3) begin
         @(negedge Clock);
         ntotal++;
         if (TxOut !== 1'b1) $display("FAIL reset_txout got %b want 1", TxOut);
         else npass++;
         ntotal++;
         if (TxEmpty !== 1'b1) $display("FAIL reset_txempty got %b want 1", TxEmpty);
         else npass++;
      end
      Reset = 1'b0;
      bad = 0;
      repeat (20) begin
         @(negedge Clock);
         if (TxOut !== 1'b1 || TxEmpty !== 1'b1) bad++;
      end
      ntotal++;
      if (bad != 0) $display("FAIL idle_quiet bad_cycles got %0d want 0", bad);
      else npass++;
   endtask

   task automatic test_frame_55();
      logic [10:0] bits; logic stable; int low;
      XMitGo = 1'b1; TxData = 8'h55;
      @(negedge Clock);
      ntotal++;
      if (TxEmpty !== 1'b0 || TxOut !== 1'b0)
         $display("FAIL f55_accept got empty=%b out=%b want 0 0", TxEmpty, TxOut);
      else npass++;
      XMitGo = 1'b0; TxData = 8'hFF;   // must be ignored while busy
      capture_frame(NB, bits, stable, low);
      ntotal++;
      if (bits !== frame_of(8'h55)) $display("FAIL f55_bits got %b want %b", bits, frame_of(8'h55));
      else npass++;
`ifndef UART_TX_PARITY_EN
      ntotal++;
      if (bits !== 11'b00_1010101010) $display("FAIL f55_seq got %b want 00_1010101010", bits);
      else npass++;
`endif
      ntotal++;
      if (stable !== 1'b1) $display("FAIL f55_bit_width got unstable want %0d-cycle bits", C);
      else npass++;
      ntotal++;
      if (low != NB * C) $display("FAIL f55_empty_low got %0d want %0d", low, NB * C);
      else npass++;
      ntotal++;
      if (TxEmpty !== 1'b1) $display("FAIL f55_empty_back got %b want 1", TxEmpty);
      else npass++;
   endtask

   task automatic test_held_high();
      logic [10:0] bits; logic stable; int low; int bad; int n;
      XMitGo = 1'b1; TxData = 8'hA3;
      @(negedge Clock);
      ntotal++;
      if (TxEmpty !== 1'b0) $display("FAIL held_accept got %b want 0", TxEmpty);
      else npass++;
      capture_frame(NB, bits, stable, low);
      ntotal++;
      if (bits !== frame_of(8'hA3)) $display("FAIL held_bits got %b want %b", bits, frame_of(8'hA3));
      else npass++;
`ifndef UART_TX_PARITY_EN
      ntotal++;
      if (bits[9:0] !== 10'b1101000110) $display("FAIL held_seq got %b want 1101000110", bits[9:0]);
      else npass++;
`endif
      bad = 0;
      n = 100 - 1 - NB * C;
      repeat (n) begin
         if (TxEmpty !== 1'b1 || TxOut !== 1'b1) bad++;
         @(negedge Clock);
      end
      ntotal++;
      if (bad != 0) $display("FAIL held_no_retrigger bad_cycles got %0d want 0", bad);
      else npass++;
      XMitGo = 1'b0;
      @(negedge Clock);
      XMitGo = 1'b1;
      @(negedge Clock);
      ntotal++;
      if (TxEmpty !== 1'b0) $display("FAIL held_rearm got %b want 0", TxEmpty);
      else npass++;
      XMitGo = 1'b0;
      capture_frame(NB, bits, stable, low);
      ntotal++;
      if (bits !== frame_of(8'hA3) || TxEmpty !== 1'b1)
         $display("FAIL held_rearm_frame got %b empty=%b want %b empty=1", bits, TxEmpty, frame_of(8'hA3));
      else npass++;
   endtask

   task automatic test_back_to_back();
      logic [7:0] msg [2];
      int cnt; logic ok;
      msg[0] = 8'h48; msg[1] = 8'h69;
      rx_q.delete(); rx_stop_q.delete(); gap_q.delete();
      for (int i = 0; i < 2; i++) begin
         XMitGo = 1'b1; TxData = msg[i];
         ok = 1'b0; cnt = 0;
         while (!ok && cnt < 20) begin
            @(negedge Clock); cnt++;
            if (TxEmpty === 1'b0) ok = 1'b1;
         end
         ntotal++;
         if (!ok) $display("FAIL b2b_accept%0d got timeout want TxEmpty low", i);
         else npass++;
         XMitGo = 1'b0;
         ok = 1'b0; cnt = 0;
         while (!ok && cnt < NB * C + 10) begin
            @(negedge Clock); cnt++;
            if (TxEmpty === 1'b1) ok = 1'b1;
         end
         ntotal++;
         if (!ok) $display("FAIL b2b_done%0d got timeout want TxEmpty high", i);
         else npass++;
      end
      repeat (4) @(negedge Clock);
      ntotal++;
      if (rx_q.size() != 2 || rx_q[0] !== 8'h48 || rx_q[1] !== 8'h69)
         $display("FAIL b2b_rx_bytes got n=%0d %h %h want 2 48 69", rx_q.size(),
                  (rx_q.size() > 0) ? rx_q[0] : 8'hxx, (rx_q.size() > 1) ? rx_q[1] : 8'hxx);
      else npass++;
      ntotal++;
      if (rx_stop_q.size() != 2 || rx_stop_q[0] !== 1'b1 || rx_stop_q[1] !== 1'b1)
         $display("FAIL b2b_stop_bits got n=%0d want 2 high stop bits", rx_stop_q.size());
      else npass++;
      // High samples left after the mid-stop sample, plus at least one idle cycle.
      ntotal++;
      if (gap_q.size() != 2 || gap_q[1] < (C - C / 2 - 1) + 1)
         $display("FAIL b2b_gap got n=%0d gap=%0d want >=%0d", gap_q.size(),
                  (gap_q.size() > 1) ? gap_q[1] : -1, C - C / 2);
      else npass++;
   endtask

   task automatic test_reset_midframe();
      logic [10:0] bits; logic stable; int low;
      XMitGo = 1'b1; TxData = 8'h00;
      @(negedge Clock);
      XMitGo = 1'b0;
      repeat (14) @(negedge Clock);
      ntotal++;
      if (TxEmpty !== 1'b0) $display("FAIL mid_busy got %b want 0", TxEmpty);
      else npass++;
      Reset = 1'b1;
      @(negedge Clock);
      ntotal++;
      if (TxOut !== 1'b1 || TxEmpty !== 1'b1)
         $display("FAIL mid_reset got out=%b empty=%b want 1 1", TxOut, TxEmpty);
      else npass++;
      Reset = 1'b0;
      repeat (3) @(negedge Clock);
      ntotal++;
      if (TxOut !== 1'b1 || TxEmpty !== 1'b1)
         $display("FAIL mid_no_resume got out=%b empty=%b want 1 1", TxOut, TxEmpty);
      else npass++;
      XMitGo = 1'b1; TxData = 8'hFF;
      @(negedge Clock);
      XMitGo = 1'b0;
      capture_frame(NB, bits, stable, low);
      ntotal++;
      if (bits !== frame_of(8'hFF) || stable !== 1'b1 || low != NB * C)
         $display("FAIL mid_clean_ff got %b stable=%b low=%0d want %b stable=1 low=%0d",
                  bits, stable, low, frame_of(8'hFF), NB * C);
      else npass++;
   endtask

`ifdef UART_TX_PARITY_EN
   task automatic test_parity();
      logic [10:0] bits; logic stable; int low;
      XMitGo = 1'b1; TxData = 8'h07;
      @(negedge Clock);
      XMitGo = 1'b0;
      capture_frame(11, bits, stable, low);
      ntotal++;
      if (bits !== 11'b11000001110) $display("FAIL par07_bits got %b want 11000001110", bits);
      else npass++;
      ntotal++;
      if (low != 44) $display("FAIL par07_len got %0d want 44", low);
      else npass++;
      @(negedge Clock);
      XMitGo = 1'b1; TxData = 8'h03;
      @(negedge Clock);
      XMitGo = 1'b0;
      capture_frame(11, bits, stable, low);
      ntotal++;
      if (bits[9] !== 1'b0 || bits !== 11'b10000000110)
         $display("FAIL par03_bits got %b want 10000000110", bits);
      else npass++;
   endtask
`endif

   initial begin
      #1000000;
      $display("FAIL watchdog got timeout want completion");
      $fatal(1, "simulation timeout");
   end

   initial begin
      test_reset();
      test_frame_55();
      @(negedge Clock);
      test_held_high();
      @(negedge Clock);
      test_back_to_back();
      @(negedge Clock);
      test_reset_midframe();
      @(negedge Clock);
`ifdef UART_TX_PARITY_EN
      test_parity();
`endif
      $display("%0d/%0d checks passed", npass, ntotal);
      $finish;
   end

endmodule
